// File: rtl/myo_status_frame_decoder_if.sv
// Word stream from the SPI front end into the Myo status frame decoder.
interface myo_status_frame_decoder_if;
  logic        frame_start;
  logic [7:0]  motor_index;
  logic        word_valid;
  logic [15:0] word_data;

  modport master (output frame_start, motor_index, word_valid, word_data);
  modport slave  (input  frame_start, motor_index, word_valid, word_data);
endinterface

// File: rtl/myo_status_frame_decoder.sv
// Assembles 7-word Myo status frames into per-motor state registers,
// with frame abort/timeout error reporting and a slot-0 update-rate meter.
module myo_status_frame_decoder #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int CLOCK_FREQ_HZ    = 50000000,
  parameter int TIMEOUT_CYCLES   = 1000
) (
  input  logic                              clock,
  input  logic                              reset_n,
  myo_status_frame_decoder_if.slave         bus,
  output logic [NUMBER_OF_MOTORS-1:0][31:0] positions,
  output logic [NUMBER_OF_MOTORS-1:0][15:0] velocities,
  output logic [NUMBER_OF_MOTORS-1:0][15:0] currents,
  output logic [NUMBER_OF_MOTORS-1:0][31:0] displacements,
  output logic                              frame_done,
  output logic [7:0]                        frame_done_motor,
  output logic                              frame_error,
  output logic [15:0]                       error_count,
  output logic [31:0]                       actual_update_frequency
);
  localparam logic [8:0] NM = 9'(NUMBER_OF_MOTORS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WW = (CLOCK_FREQ_HZ > 1) ? $clog2(CLOCK_FREQ_HZ) : 1;

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  state_t          r_state, w_nxt;
  logic [7:0]      r_idx;
  logic [2:0]      r_wcnt;
  logic [15:0]     r_sh [1:6];
  logic [TW-1:0]   r_timer;
  logic [WW-1:0]   r_win;
  logic [31:0]     r_rate_cnt;
  logic            w_idx_ok, w_start, w_store, w_commit, w_err;
  logic            w_wrap, w_commit0;

  assign w_idx_ok  = {1'b0, bus.motor_index} < NM;
  assign w_wrap    = (r_win == WW'(CLOCK_FREQ_HZ - 1));
  assign w_commit0 = w_commit && (r_idx == 8'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_store  = 1'b0;
    w_commit = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.frame_start) begin
          if (w_idx_ok) begin w_start = 1'b1; w_nxt = RECV; end
          else            w_err = 1'b1;
        end
      end
      RECV: begin
        // A new frame_start always aborts the frame in flight
        if (bus.frame_start) begin
          w_err = 1'b1;
          if (w_idx_ok) begin w_start = 1'b1; w_nxt = RECV; end
          else            w_nxt = IDLE;
        end else if (bus.word_valid) begin
          w_store = 1'b1;
          if (r_wcnt == 3'd6) w_nxt = COMMIT;
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_err = 1'b1;
          w_nxt = IDLE;
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_nxt    = IDLE;
        if (bus.frame_start) begin
          if (w_idx_ok) begin w_start = 1'b1; w_nxt = RECV; end
          else            w_err = 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_idx                   <= '0;
      r_wcnt                  <= '0;
      r_timer                 <= '0;
      r_win                   <= '0;
      r_rate_cnt              <= '0;
      for (int k = 1; k <= 6; k++) r_sh[k] <= '0;
      positions               <= '0;
      velocities              <= '0;
      currents                <= '0;
      displacements           <= '0;
      frame_done              <= 1'b0;
      frame_done_motor        <= '0;
      frame_error             <= 1'b0;
      error_count             <= '0;
      actual_update_frequency <= '0;
    end else begin
      frame_done  <= w_commit;
      frame_error <= w_err;
      if (w_err && error_count != 16'hFFFF) error_count <= error_count + 16'd1;

      // w0 is status only, so a coincident word just advances the counter
      if (w_start) begin
        r_idx   <= bus.motor_index;
        r_wcnt  <= bus.word_valid ? 3'd1 : 3'd0;
        r_timer <= '0;
      end else if (w_store) begin
        for (int k = 1; k <= 6; k++)
          if (r_wcnt == 3'(k)) r_sh[k] <= bus.word_data;
        r_wcnt  <= r_wcnt + 3'd1;
        r_timer <= '0;
      end else if (r_state == RECV) begin
        r_timer <= r_timer + TW'(1);
      end

      if (w_commit) begin
        for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
          if (r_idx == 8'(m)) begin
            positions[m]     <= {r_sh[1], r_sh[2]};
            velocities[m]    <= r_sh[3];
            currents[m]      <= r_sh[4];
            displacements[m] <= {r_sh[5], r_sh[6]};
          end
        end
        frame_done_motor <= r_idx;
      end

      if (w_wrap) begin
        r_win                   <= '0;
        actual_update_frequency <= r_rate_cnt + 32'(w_commit0);
        r_rate_cnt              <= '0;
      end else begin
        r_win      <= r_win + WW'(1);
        r_rate_cnt <= r_rate_cnt + 32'(w_commit0);
      end
    end
  end
endmodule

// File: tb/tb_myo_status_frame_decoder.sv
// Directed bench for the status frame decoder: commit, reject, abort, timeout,
// rate window and mid-frame reset.
module tb_myo_status_frame_decoder;
  localparam int NM = 6;

  typedef logic [15:0] frame_t [7];

  logic clock = 1'b0;
  logic reset_n;
  logic [NM-1:0][31:0] positions, displacements;
  logic [NM-1:0][15:0] velocities, currents;
  logic        frame_done, frame_error;
  logic [7:0]  frame_done_motor;
  logic [15:0] error_count;
  logic [31:0] actual_update_frequency;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  myo_status_frame_decoder_if bus();

  myo_status_frame_decoder #(
    .NUMBER_OF_MOTORS(NM), .CLOCK_FREQ_HZ(100), .TIMEOUT_CYCLES(10)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .positions(positions), .velocities(velocities), .currents(currents),
    .displacements(displacements), .frame_done(frame_done),
    .frame_done_motor(frame_done_motor), .frame_error(frame_error),
    .error_count(error_count), .actual_update_frequency(actual_update_frequency)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (frame_done) done_cnt++;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic chk_slot(input int s, input logic [31:0] p, input logic [31:0] v,
                          input logic [31:0] c, input logic [31:0] d);
    chk($sformatf("pos[%0d]", s),  positions[s], p);
    chk($sformatf("vel[%0d]", s),  32'($signed(velocities[s])), v);
    chk($sformatf("cur[%0d]", s),  32'($signed(currents[s])), c);
    chk($sformatf("disp[%0d]", s), displacements[s], d);
  endtask

  // w0 rides on the frame_start cycle; commit lands one clock after the w6 edge
  task automatic send_frame(input logic [7:0] idx, input frame_t w, input logic exp_err);
    bus.frame_start = 1'b1; bus.motor_index = idx;
    bus.word_valid  = 1'b1; bus.word_data   = w[0];
    tick();
    chk("start_err", frame_error, exp_err);
    bus.frame_start = 1'b0;
    for (int i = 1; i < 7; i++) begin
      bus.word_data = w[i];
      tick();
    end
    bus.word_valid = 1'b0;
    chk("done_early", frame_done, 0);
    tick();
    chk("done", frame_done, 1);
    chk("done_motor", frame_done_motor, idx);
    tick();
    chk("done_1cyc", frame_done, 0);
  endtask

  frame_t fa = '{16'h00AA, 16'hFFFF, 16'hFFFE, 16'h8000, 16'h0010, 16'h0001, 16'h0000};
  frame_t fb = '{16'h0000, 16'h1234, 16'h5678, 16'h0100, 16'hFF00, 16'h8000, 16'h0001};
  frame_t fc = '{16'h0000, 16'h0000, 16'h0007, 16'h7FFF, 16'h0002, 16'hFFFF, 16'hFFFF};
  frame_t fd = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0005};

  initial begin
    int d0;
    bit seen;
    reset_n = 1'b0;
    bus.frame_start = 1'b0; bus.motor_index = '0;
    bus.word_valid  = 1'b0; bus.word_data   = '0;
    tick(); tick();
    chk("rst_pos0", positions[0], 0);
    chk("rst_disp5", displacements[5], 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err_cnt", error_count, 0);
    chk("rst_rate", actual_update_frequency, 0);
    reset_n = 1'b1;

    // Rate window: 3 slot-0 and 2 slot-1 commits in the first window
    send_frame(8'd0, fb, 1'b0);
    chk_slot(0, 32'h12345678, 256, -256, 32'h80000001);
    send_frame(8'd1, fc, 1'b0);
    chk_slot(1, 7, 32767, 2, -1);
    send_frame(8'd0, fb, 1'b0);
    send_frame(8'd1, fc, 1'b0);
    send_frame(8'd0, fb, 1'b0);
    chk("rate_prewrap", actual_update_frequency, 0);
    seen = 0;
    for (int i = 0; i < 150 && !seen; i++) begin
      tick();
      if (actual_update_frequency != 0) seen = 1;
    end
    chk("rate_wrap_seen", 32'(seen), 1);
    chk("rate", actual_update_frequency, 3);

    // Mixed-sign field assembly to slot 2, neighbours untouched
    send_frame(8'd2, fa, 1'b0);
    chk_slot(2, -2, -32768, 16, 65536);
    chk_slot(0, 32'h12345678, 256, -256, 32'h80000001);
    chk("pos1_kept", positions[1], 7);

    // Out-of-range slot rejected; following words ignored
    d0 = done_cnt;
    bus.frame_start = 1'b1; bus.motor_index = 8'd6;
    tick();
    bus.frame_start = 1'b0;
    chk("bad_idx_err", frame_error, 1);
    chk("bad_idx_cnt", error_count, 1);
    bus.word_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.word_data = fc[i];
      tick();
    end
    bus.word_valid = 1'b0;
    tick(); tick();
    chk("bad_idx_err_1cyc", frame_error, 0);
    chk("bad_idx_nocommit", 32'(done_cnt - d0), 0);
    chk("bad_idx_pos2", positions[2], -2);

    // Abort slot 1 after 3 words by starting slot 0
    bus.frame_start = 1'b1; bus.motor_index = 8'd1;
    bus.word_valid  = 1'b1; bus.word_data   = 16'h0000;
    tick();
    bus.frame_start = 1'b0;
    bus.word_data = 16'hAAAA; tick();
    bus.word_data = 16'hBBBB; tick();
    send_frame(8'd0, fd, 1'b1);
    chk("abort_cnt", error_count, 2);
    chk_slot(1, 7, 32767, 2, -1);
    chk_slot(0, -1, 0, 0, 5);

    // Timeout: 4 words then 10 idle clocks
    d0 = done_cnt;
    bus.frame_start = 1'b1; bus.motor_index = 8'd3;
    bus.word_valid  = 1'b1; bus.word_data   = 16'h0000;
    tick();
    bus.frame_start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      bus.word_data = 16'h1111 * 16'(i);
      tick();
    end
    bus.word_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("to_not_yet", frame_error, 0);
    tick();
    chk("to_err", frame_error, 1);
    chk("to_cnt", error_count, 3);
    tick();
    chk("to_nocommit", 32'(done_cnt - d0), 0);
    chk("to_pos3", positions[3], 0);
    send_frame(8'd3, fc, 1'b0);
    chk_slot(3, 7, 32767, 2, -1);

    // Reset after w4, then a clean frame
    d0 = done_cnt;
    bus.frame_start = 1'b1; bus.motor_index = 8'd4;
    bus.word_valid  = 1'b1; bus.word_data   = fa[0];
    tick();
    bus.frame_start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      bus.word_data = fa[i];
      tick();
    end
    bus.word_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_pos2", positions[2], 0);
    chk("mrst_vel0", 32'(velocities[0]), 0);
    chk("mrst_err_cnt", error_count, 0);
    chk("mrst_done_motor", frame_done_motor, 0);
    chk("mrst_rate", actual_update_frequency, 0);
    chk("mrst_err", frame_error, 0);
    tick(); tick();
    chk("mrst_nocommit", 32'(done_cnt - d0), 0);
    chk("mrst_err_after", error_count, 0);
    send_frame(8'd4, fa, 1'b0);
    chk_slot(4, -2, -32768, 16, 65536);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/myo_status_frame_decoder.md
MYO_STATUS_FRAME_DECODER -- requirements
Module: myo_status_frame_decoder

Interface
REQ-001 SHALL have parameter NUMBER_OF_MOTORS, default 6: number of motor state slots, legal range 1..255.
REQ-002 SHALL have parameter CLOCK_FREQ_HZ, default 50000000: length in clocks of the rate-measurement window.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000: maximum idle gap in clocks between words of one frame.
REQ-004 clock  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 frame_start  in  1  one-cycle strobe that begins a frame and samples motor_index.
REQ-007 motor_index  in  8  target motor slot of the frame.
REQ-008 word_valid  in  1  word_data is valid this cycle.
REQ-009 word_data  in  16  received SPI status word.
REQ-010 positions  out  signed 32 x NUMBER_OF_MOTORS  motor positions.
REQ-011 velocities  out  signed 16 x NUMBER_OF_MOTORS  motor velocities.
REQ-012 currents  out  signed 16 x NUMBER_OF_MOTORS  motor currents.
REQ-013 displacements  out  signed 32 x NUMBER_OF_MOTORS  spring displacements.
REQ-014 frame_done  out  1  one-cycle pulse on each commit.
REQ-015 frame_done_motor  out  8  slot of the last commit; held until the next commit.
REQ-016 frame_error  out  1  one-cycle pulse on each rejected or aborted frame.
REQ-017 error_count  out  16  count of frame_error pulses; saturates at 0xFFFF.
REQ-018 actual_update_frequency  out  32  commits to slot 0 in the last completed window.

Function
REQ-019 SHALL implement the states IDLE, RECV and COMMIT.
REQ-020 Frame format SHALL be 7 words in order w0..w6: w0 status (discarded), w1 pos[31:16], w2 pos[15:0], w3 velocity, w4 current, w5 disp[31:16], w6 disp[15:0].
REQ-021 IDLE: when frame_start=1 and motor_index < NUMBER_OF_MOTORS, the block SHALL latch the index, clear the word counter and enter RECV.
REQ-022 IDLE: when frame_start=1 and motor_index >= NUMBER_OF_MOTORS, the block SHALL pulse frame_error, stay in IDLE and ignore words until the next valid frame_start.
REQ-023 word_valid in IDLE without frame_start SHALL be ignored.
REQ-024 A word_valid coincident with an accepted frame_start SHALL be taken as w0 of the new frame.
REQ-025 RECV: each word_valid SHALL store word_data into the shadow register selected by the word counter and increment the counter.
REQ-026 Acceptance of w6 SHALL move the block to COMMIT.
REQ-027 Outputs SHALL NOT change while a frame is being received.
REQ-028 COMMIT: on the clock edge after w6 is accepted, the block SHALL write all four fields of the latched slot in the same cycle, assert frame_done for exactly one cycle, set frame_done_motor, and return to IDLE.
REQ-029 Commit latency SHALL be exactly 1 clock after the w6 edge.
REQ-030 Field assembly: position = {w1,w2}; velocity = w3; current = w4; displacement = {w5,w6}; all two's complement with no sign extension or scaling.
REQ-031 frame_start in RECV SHALL abort the current frame: pulse frame_error, discard the partial data, and restart per REQ-021/REQ-022 in the same cycle.
REQ-032 frame_start in COMMIT SHALL let the commit complete and SHALL start the new frame without an error; word_valid in COMMIT without frame_start SHALL be ignored.
REQ-033 RECV timeout: after TIMEOUT_CYCLES consecutive clocks without word_valid, the block SHALL pulse frame_error, return to IDLE and perform no commit.
REQ-034 error_count SHALL increment by 1 per frame_error pulse and saturate at 0xFFFF.
REQ-035 Rate window: a free-running counter SHALL cycle 0..CLOCK_FREQ_HZ-1; a commit counter SHALL count commits to slot 0.
REQ-036 In the cycle the window counter wraps, actual_update_frequency SHALL load the commit count, including any commit in that cycle, and the commit count SHALL restart at 0.

Reset
REQ-037 When reset_n=0 at a clock edge, the block SHALL go to IDLE and clear every output, shadow register and counter to 0 (including error_count, actual_update_frequency, frame_done_motor), taking effect on that edge.
REQ-038 Reset mid-frame SHALL discard the partial frame with no commit and no frame_error.

Verification
REQ-039 Frame to slot 2, words 0x00AA,0xFFFF,0xFFFE,0x8000,0x0010,0x0001,0x0000 -> one cycle after w6: positions[2]=-2, velocities[2]=-32768, currents[2]=16, displacements[2]=65536, frame_done=1 for 1 cycle, frame_done_motor=2; other slots unchanged.
REQ-040 frame_start with motor_index=6 (NUMBER_OF_MOTORS=6), then 7 words -> frame_error pulse, error_count=1, no output change.
REQ-041 Slot 1 frame: 3 words, then frame_start for slot 0 and 7 words -> one frame_error pulse, slot 1 unchanged, slot 0 committed.
REQ-042 TIMEOUT_CYCLES=10: 4 words then 10 idle clocks -> frame_error pulse, state IDLE, no commit.
REQ-043 CLOCK_FREQ_HZ=100: 3 complete slot-0 frames and 2 slot-1 frames within one window -> actual_update_frequency=3 after the wrap.
REQ-044 reset_n=0 for 1 clock after w4 of a frame -> all outputs 0 and no frame_done; the next complete frame commits normally.
